// File: rtl/rotr_seq_unit_pkg.sv
// Shared rotate-unit definitions: state encoding, data width and stage count.
// Usable by both the rotate-right (this unit) and circular-shift-left side.
package rotr_seq_unit_pkg;

  localparam int ROT_WIDTH  = 16;
  localparam int ROT_STAGES = $clog2(ROT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rot_state_e;

  // Width of a stage index; a single-stage unit still needs one bit.
  function automatic int stage_idx_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/rotr_seq_unit_if.sv
// Request/result handshake bundle between the execute-stage controller
// (master) and the rotate-right unit (slave).
interface rotr_seq_unit_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] amount;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  modport master (
    output in_valid, din, amount, abort, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, amount, abort, out_ready,
    output in_ready, out_valid, dout, busy
  );

endinterface

// File: rtl/rotr_seq_unit_stage.sv
// One barrel stage: rotate right by 2**k when enabled, else pass through.
// k is a run-time select so one instance serves every stage in turn.
module rotr_stage #(
  parameter int WIDTH = 16,
  parameter int SW    = 2
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [SW-1:0]    k,
  output logic [WIDTH-1:0] dout
);

  logic [2*WIDTH-1:0] dbl;

  // Rotate via a doubled word shifted right; the low half is the result.
  always_comb begin
    dbl  = {din, din} >> (32'd1 << k);
    dout = en ? dbl[WIDTH-1:0] : din;
  end

endmodule

// File: rtl/rotr_seq_unit.sv
// Sequential rotate-right unit: one barrel stage resolved per clock.
// Optional macro ROTR_ZERO_SKIP_EN: only act on set amount bits (lowest first),
// giving latency max(1, popcount(amount)) instead of a fixed stage count.
module rotr_seq_unit
  import rotr_seq_unit_pkg::*;
#(
  parameter int WIDTH = ROT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  rotr_seq_unit_if.slave   bus
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int SW     = stage_idx_width(STAGES);

  rot_state_e        state;
  logic [WIDTH-1:0]  data_r;
  logic [STAGES-1:0] amt_r;
  logic [SW-1:0]     sel;
  logic              en;
  logic [WIDTH-1:0]  stage_out;

  // Only the low amount bits matter; rotation is modulo WIDTH.
  logic unused_amt_hi;
  assign unused_amt_hi = ^bus.amount[WIDTH-1:STAGES];

`ifdef ROTR_ZERO_SKIP_EN
  logic [STAGES-1:0] amt_next;

  // Lowest set bit of the remaining amount picks the stage to apply.
  always_comb begin
    sel = '0;
    for (int unsigned i = STAGES; i > 0; i--) begin
      if (amt_r[i-1]) sel = SW'(i-1);
    end
    en       = 1'b1;
    amt_next = amt_r & (amt_r - STAGES'(1));
  end
`else
  logic [SW-1:0] stage;

  // Fixed walk through the stages; each applies only if its amount bit is set.
  always_comb begin
    sel = stage;
    en  = amt_r[stage];
  end
`endif

  rotr_stage #(.WIDTH(WIDTH), .SW(SW)) u_stage (
    .din  (data_r),
    .en   (en),
    .k    (sel),
    .dout (stage_out)
  );

  // Control FSM and datapath registers; abort overrides every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_r <= '0;
      amt_r  <= '0;
`ifndef ROTR_ZERO_SKIP_EN
      stage  <= '0;
`endif
    end else if (bus.abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_r <= bus.din;
            amt_r  <= bus.amount[STAGES-1:0];
`ifdef ROTR_ZERO_SKIP_EN
            state  <= (bus.amount[STAGES-1:0] == '0) ? ST_DONE : ST_SHIFT;
`else
            stage  <= '0;
            state  <= ST_SHIFT;
`endif
          end
        end
        ST_SHIFT: begin
          data_r <= stage_out;
`ifdef ROTR_ZERO_SKIP_EN
          amt_r  <= amt_next;
          if (amt_next == '0) state <= ST_DONE;
`else
          stage  <= stage + SW'(1);
          if (stage == SW'(STAGES-1)) state <= ST_DONE;
`endif
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
    bus.busy      = (state != ST_IDLE);
    bus.dout      = data_r;
  end

endmodule

// File: tb/tb_rotr_seq_unit.sv
// Self-checking bench for rotr_seq_unit: directed corner cases followed by
// random operations checked against a rotate-left-based reference.
module tb_rotr_seq_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rotr_seq_unit_if #(.WIDTH(16)) bus ();

  rotr_seq_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Circular shift left by n, one bit at a time.
  function automatic logic [15:0] csl(input logic [15:0] x, input int n);
    logic [15:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  // Rotate right by amt expressed as rotate left by the complement.
  function automatic logic [15:0] rotr_ref(input logic [15:0] x, input int unsigned amt);
    int n;
    n = int'(amt % 16);
    return csl(x, (16 - n) % 16);
  endfunction

  function automatic int exp_latency(input int unsigned amt);
`ifdef ROTR_ZERO_SKIP_EN
    int p;
    p = $countones(amt % 16);
    return (p == 0) ? 1 : p;
`else
    return 4;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result with a bound, hold it for hold cycles, accept.
  task automatic do_op(input logic [15:0] x, input logic [15:0] amt, input int hold);
    logic [15:0] e;
    int lat;
    e = rotr_ref(x, amt);
    @(negedge clk);
    check("in_ready_before", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.din      = x;
    bus.amount   = amt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    check("latency", lat, exp_latency(amt));
    check("dout", {16'd0, bus.dout}, {16'd0, e});
    check("csl_inverse", {16'd0, csl(bus.dout, int'(amt % 16))}, {16'd0, x});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_dout", {16'd0, bus.dout}, {16'd0, e});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_after_accept", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] e;
    int lat;
    logic saw_valid;

    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.amount    = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_dout", {16'd0, bus.dout}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed values from the datasheet examples.
    do_op(16'h0001, 16'h0001, 0);
    check("ex1", {16'd0, rotr_ref(16'h0001, 1)}, 32'h8000);
    do_op(16'h1234, 16'h0004, 0);
    do_op(16'h000F, 16'h0013, 0);
    check("ex2_modulo", {16'd0, rotr_ref(16'h000F, 16'h0013)}, 32'hE001);
    do_op(16'hA5C3, 16'h0000, 0);
    do_op(16'hBEEF, 16'hFFFF, 1);

    // Stall: consumer not ready while a new request is presented.
    e = rotr_ref(16'h1357, 5);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 16'h1357; bus.amount = 16'd5;
    @(posedge clk); #1;
    bus.din = 16'hFFFF; bus.amount = 16'd3;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    check("stall_latency", lat, exp_latency(5));
    for (int h = 0; h < 6; h++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_dout", {16'd0, bus.dout}, {16'd0, e});
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stall_release_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check("stall_no_second", {31'd0, bus.busy}, 32'd0);

    // Abort in the second SHIFT cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 16'hC0DE; bus.amount = 16'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_idle", {31'd0, bus.in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int h = 0; h < 8; h++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", {31'd0, saw_valid}, 32'd0);

    // Abort beats a simultaneous request in IDLE.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.abort = 1'b1; bus.din = 16'h1111; bus.amount = 16'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    check("abort_blocks_accept", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 16'h5A5A; bus.amount = 16'd15;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_dout", {16'd0, bus.dout}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random operations.
    for (int i = 0; i < 1000; i++) begin
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
